// File: rtl/fb_pkg.sv
// Shared framebuffer constants, swap-FSM states and the round-robin pick helper
// used by the framebuffer read scheduler.
package fb_pkg;

  localparam int FB_BYTECOUNT = 336;
  localparam int FB_ADDR_W    = 9;
  localparam int FB_DATA_W    = 8;

  // Widest requester vector rr_pick handles; arbiters use the low NUM_PORTS bits.
  localparam int RR_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_DRAIN,
    ST_SWAP
  } swap_state_t;

  // One-hot pick of the first set bit of req, searching from ptr+1 and wrapping at n.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input logic [3:0]        ptr,
                                                input logic [4:0]        n);
    logic [RR_MAX-1:0] pick;
    logic              found;
    logic [5:0]        idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = 6'(ptr) + 6'(k);
      if (idx >= 6'(n)) begin
        idx = idx - 6'(n);
      end
      if (!found && (k <= int'(n)) && req[idx[3:0]]) begin
        pick[idx[3:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer moves to the winner.
// NUM_PORTS must stay below fb_pkg::RR_MAX.
module rr_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  gnt_idx;
  logic [RR_MAX-1:0] req_ext;
  logic [RR_MAX-1:0] pick;
  logic              unused_pick_hi;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_PORTS-1:0]   = req;
    pick                     = rr_pick(req_ext, 4'(ptr_reg), 5'(NUM_PORTS));
    gnt                      = en ? pick[NUM_PORTS-1:0] : '0;
  end

  assign unused_pick_hi = ^pick[RR_MAX-1:NUM_PORTS];

  always_comb begin
    gnt_idx = ptr_reg;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        gnt_idx = PTR_W'(i);
      end
    end
  end

  // Starting at NUM_PORTS-1 makes port 0 the first choice after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= PTR_W'(NUM_PORTS - 1);
    end else if (|gnt) begin
      ptr_reg <= gnt_idx;
    end
  end

endmodule

// File: rtl/fb_read_scheduler.sv
// Shares one framebuffer read port among the matrix drivers and owns the
// double-buffer bank select, flipping only between frames with no reads in flight.
module fb_read_scheduler
  import fb_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_PORTS-1:0]        rvalid,
  input  logic [NUM_PORTS-1:0]        frame_done,
  input  logic                        swap_req,
  output logic                        swap_pending,
  output logic                        swap_ack,
  output logic                        front_sel,
  output logic                        mem_rd,
  output logic [ADDR_W:0]             mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata
);

  swap_state_t            state_reg, state_next;
  logic [NUM_PORTS-1:0]   mask_reg, mask_next;
  logic                   front_sel_reg;
  logic [NUM_PORTS-1:0]   tag_reg [RD_LATENCY];
  logic [RD_LATENCY-1:0]  stage_busy;
  logic                   in_flight;
  logic [DATA_W-1:0]      rdata_reg;
  logic                   grant_en;
  logic [ADDR_W-1:0]      addr_masked [NUM_PORTS];
  logic [ADDR_W-1:0]      sel_addr;

  assign grant_en = (state_reg != ST_SWAP);

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (grant_en),
    .req (req),
    .gnt (gnt)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_addr
      assign addr_masked[gi] = gnt[gi] ? addr[gi*ADDR_W +: ADDR_W] : '0;
    end
  endgenerate

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel_addr = sel_addr | addr_masked[i];
    end
  end

  assign mem_rd   = |gnt;
  assign mem_addr = mem_rd ? {front_sel_reg, sel_addr} : '0;

  // The tag pipeline mirrors the RAM latency so rvalid lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_reg[i] <= '0;
      end
    end else begin
      tag_reg[0] <= gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_busy
      assign stage_busy[gi] = |tag_reg[gi];
    end
  endgenerate

  assign in_flight = |stage_busy;
  assign rvalid    = tag_reg[RD_LATENCY-1];

  // Data passes straight through on its valid cycle and is held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (|rvalid) begin
      rdata_reg <= mem_rdata;
    end
  end

  assign rdata = (|rvalid) ? mem_rdata : rdata_reg;

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    swap_ack   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (swap_req) begin
          state_next = ST_PENDING;
          mask_next  = '0;
        end
      end
      ST_PENDING: begin
        mask_next = mask_reg | frame_done;
        if (&mask_next) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!(|req) && !in_flight) begin
          state_next = ST_SWAP;
        end
      end
      ST_SWAP: begin
        swap_ack   = 1'b1;
        mask_next  = '0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      mask_reg      <= '0;
      front_sel_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      if (state_reg == ST_SWAP) begin
        front_sel_reg <= ~front_sel_reg;
      end
    end
  end

  assign front_sel    = front_sel_reg;
  assign swap_pending = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Drives two schedulers (RAM latency 1 and 2) with shared stimulus and checks
// each against its own behavioural model every cycle.
module tb_fb_read_scheduler;

  localparam int N = 3;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [26:0] addr;
  logic [2:0]  frame_done;
  logic        swap_req;

  logic [2:0] gnt0, rvalid0, gnt1, rvalid1;
  logic [7:0] rdata0, rdata1, mem_rdata0, mem_rdata1, ram_stage1;
  logic       swap_pending0, swap_ack0, front_sel0, mem_rd0;
  logic       swap_pending1, swap_ack1, front_sel1, mem_rd1;
  logic [9:0] mem_addr0, mem_addr1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic       fixed_addr = 1'b0;
  logic [8:0] fixed_val  = 9'd0;

  // Model state, indexed by DUT (0: latency 1, 1: latency 2).
  int         m_ptr   [2];
  int         m_phase [2];   // 0 idle, 1 waiting for frames, 2 draining, 3 flipping
  logic [2:0] m_mask  [2];
  logic       m_front [2];
  logic [7:0] m_hold  [2];
  logic [2:0] m_tag   [2][2];
  logic [9:0] m_taddr [2][2];
  logic [2:0] e_gnt   [2];
  logic [9:0] e_addr  [2];

  fb_read_scheduler #(.RD_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt0), .rdata(rdata0),
    .rvalid(rvalid0), .frame_done(frame_done), .swap_req(swap_req),
    .swap_pending(swap_pending0), .swap_ack(swap_ack0), .front_sel(front_sel0),
    .mem_rd(mem_rd0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0)
  );

  fb_read_scheduler #(.RD_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt1), .rdata(rdata1),
    .rvalid(rvalid1), .frame_done(frame_done), .swap_req(swap_req),
    .swap_pending(swap_pending1), .swap_ack(swap_ack1), .front_sel(front_sel1),
    .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_val(input logic [9:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd37;
    return t[8:1] ^ (a[9] ? 8'hA5 : 8'h00);
  endfunction

  // Behavioural RAMs: latency 1 for dut0, latency 2 for dut1.
  always @(posedge clk) begin
    mem_rdata0 <= ram_val(mem_addr0);
    ram_stage1 <= ram_val(mem_addr1);
    mem_rdata1 <= ram_stage1;
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [2:0] exp_pick(input int d, input logic [2:0] r);
    if (m_phase[d] == 3) return 3'b000;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr[d] + k) % N;
      if (r[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  task automatic model_reset(input int d);
    m_ptr[d]   = N - 1;
    m_phase[d] = 0;
    m_mask[d]  = 3'b000;
    m_front[d] = 1'b0;
    m_hold[d]  = 8'h00;
    for (int j = 0; j < 2; j++) begin
      m_tag[d][j]   = 3'b000;
      m_taddr[d][j] = 10'd0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      logic [2:0] g, rv, tout;
      logic [7:0] rd;
      logic [9:0] ma;
      logic       mr, sp, sa, fs;
      int         l, gi;
      string      p;
      if (d == 0) begin
        g = gnt0; rv = rvalid0; rd = rdata0; ma = mem_addr0; mr = mem_rd0;
        sp = swap_pending0; sa = swap_ack0; fs = front_sel0;
      end else begin
        g = gnt1; rv = rvalid1; rd = rdata1; ma = mem_addr1; mr = mem_rd1;
        sp = swap_pending1; sa = swap_ack1; fs = front_sel1;
      end
      l        = lat(d);
      e_gnt[d] = exp_pick(d, req);
      gi       = 0;
      for (int i = 0; i < N; i++) if (e_gnt[d][i]) gi = i;
      e_addr[d] = (e_gnt[d] == 3'b000) ? 10'd0 : {m_front[d], addr[gi*9 +: 9]};
      tout      = m_tag[d][l-1];
      p = $sformatf("L%0d c%0d", l, cyc);
      chk({p, " gnt"},          32'(g),  32'(e_gnt[d]));
      chk({p, " mem_rd"},       32'(mr), 32'(e_gnt[d] != 3'b000));
      chk({p, " mem_addr"},     32'(ma), 32'(e_addr[d]));
      chk({p, " rvalid"},       32'(rv), 32'(tout));
      chk({p, " rdata"},        32'(rd),
          32'((tout != 3'b000) ? ram_val(m_taddr[d][l-1]) : m_hold[d]));
      chk({p, " swap_pending"}, 32'(sp), 32'(m_phase[d] != 0));
      chk({p, " swap_ack"},     32'(sa), 32'(m_phase[d] == 3));
      chk({p, " front_sel"},    32'(fs), 32'(m_front[d]));
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_reset(d);
      end else begin
        int   l;
        logic busy;
        l    = lat(d);
        busy = 1'b0;
        for (int j = 0; j < l; j++) busy = busy | (m_tag[d][j] != 3'b000);
        if (m_tag[d][l-1] != 3'b000) m_hold[d] = ram_val(m_taddr[d][l-1]);
        for (int j = l - 1; j > 0; j--) begin
          m_tag[d][j]   = m_tag[d][j-1];
          m_taddr[d][j] = m_taddr[d][j-1];
        end
        m_tag[d][0]   = e_gnt[d];
        m_taddr[d][0] = e_addr[d];
        for (int i = 0; i < N; i++) if (e_gnt[d][i]) m_ptr[d] = i;
        case (m_phase[d])
          0: if (swap_req) begin m_phase[d] = 1; m_mask[d] = 3'b000; end
          1: begin
            m_mask[d] = m_mask[d] | frame_done;
            if (m_mask[d] == 3'b111) m_phase[d] = 2;
          end
          2: if (req == 3'b000 && !busy) m_phase[d] = 3;
          default: begin m_front[d] = ~m_front[d]; m_mask[d] = 3'b000; m_phase[d] = 0; end
        endcase
      end
    end
  endtask

  task automatic tick();
    #1;
    check_cycle();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] fd, input logic sr);
    req        = r;
    frame_done = fd;
    swap_req   = sr;
    for (int i = 0; i < N; i++) begin
      addr[i*9 +: 9] = fixed_addr ? fixed_val : 9'($urandom_range(0, 335));
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; addr = '0; frame_done = 3'b000; swap_req = 1'b0;
    repeat (2) @(posedge clk);
    model_reset(0);
    model_reset(1);
    #1;
    tick();                                   // reset state
    rst = 1'b0;

    repeat (6) step(3'b111, 3'b000, 1'b0);    // full-rate rotation 001,010,100,...
    step(3'b000, 3'b000, 1'b0);
    step(3'b001, 3'b000, 1'b0);               // pointer -> 0
    repeat (3) step(3'b101, 3'b000, 1'b0);    // 100,001,100
    repeat (2) step(3'b000, 3'b000, 1'b0);

    step(3'(($urandom)), 3'b000, 1'b1);       // swap request
    step(3'(($urandom)), 3'b001, 1'b0);
    step(3'(($urandom)), 3'b100, 1'b0);
    step(3'(($urandom)), 3'b001, 1'b0);       // repeat pulse is idempotent
    step(3'(($urandom)), 3'b010, 1'b0);       // mask complete
    fixed_addr = 1'b1;
    fixed_val  = 9'd335;
    repeat (5) step(3'b001, 3'b000, 1'b0);    // drain held off by requests
    repeat (4) step(3'b000, 3'b000, 1'b0);    // drain, flip
    repeat (2) step(3'b001, 3'b000, 1'b0);    // bank 1 reads of 335
    fixed_addr = 1'b0;
    repeat (2) step(3'b000, 3'b000, 1'b0);

    step(3'(($urandom)), 3'b111, 1'b1);       // coinciding frame_done not counted
    repeat (3) step(3'(($urandom)), 3'b000, 1'b0);
    step(3'(($urandom)), 3'b010, 1'b1);       // extra swap_req absorbed
    step(3'(($urandom)), 3'b101, 1'b0);
    repeat (5) step(3'b000, 3'b000, 1'b0);
    repeat (3) step(3'b111, 3'b000, 1'b0);

    for (int n = 0; n < 250; n++) begin
      step(3'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
           ($urandom_range(0, 24) == 0));
    end
    repeat (6) step(3'b000, 3'b000, 1'b0);

    step(3'b000, 3'b000, 1'b1);               // pending swap
    step(3'b001, 3'b000, 1'b0);               // grant, then reset next cycle
    rst = 1'b1;
    step(3'b000, 3'b000, 1'b0);
    rst = 1'b0;
    repeat (4) step(3'b000, 3'b000, 1'b0);    // no rvalid, no swap pending
    step(3'b010, 3'b000, 1'b0);
    repeat (3) step(3'b000, 3'b000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
